// File: rtl/nanov_fetch.sv
// Instruction fetch and sequencer for the bit-serial nanoV core: streams instructions
// from an SPI flash (READ 0x03), drives cycle/counter/serial pc and redirects on branch.
module nanov_fetch #(
  parameter logic [23:0] RESET_ADDR = 24'h000000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        spi_miso,
  output logic        spi_select,
  output logic        spi_clk_en,
  output logic        spi_mosi,
  output logic [31:0] instr,
  output logic [2:0]  cycle,
  output logic [4:0]  counter,
  output logic        pc,
  input  logic        branch,
  input  logic [31:0] data_out
);

  localparam logic [7:0]  CMD_READ  = 8'h03;
  localparam logic [31:0] INSTR_NOP = 32'h00000013;

  typedef enum logic [2:0] {
    ST_START,
    ST_CMD,
    ST_ADDR,
    ST_FILL,
    ST_EXEC
  } state_t;

  state_t      state_reg, state_next;
  logic [4:0]  bit_cnt_reg, bit_cnt_next;
  logic [31:0] shadow_reg, shadow_next;
  logic [31:0] instr_reg, instr_next;
  logic [2:0]  cycle_reg, cycle_next;
  logic [4:0]  counter_reg, counter_next;
  logic [31:0] pc_reg, pc_next;
  logic        branch_pending_reg, branch_pending_next;

  logic [6:0]  opcode;
  logic        is_jal;
  logic        is_shift;
  logic [2:0]  last_cycle;
  logic [4:0]  sample_idx;
  logic [31:0] shadow_fill;
  logic        take_branch;

  assign opcode     = instr_reg[6:0];
  assign is_jal     = (opcode == 7'b1101111);
  assign is_shift   = ((opcode == 7'b0010011) || (opcode == 7'b0110011)) && (instr_reg[13:12] == 2'b01);
  assign last_cycle = (is_jal || is_shift) ? 3'd1 : 3'd0;

  // Received bit k lands in byte k/8, MSB first within the byte.
  always_comb begin
    sample_idx  = (state_reg == ST_FILL) ? bit_cnt_reg : counter_reg;
    shadow_fill = shadow_reg;
    shadow_fill[{sample_idx[4:3], ~sample_idx[2:0]}] = spi_miso;
  end

  always_comb begin
    state_next          = state_reg;
    bit_cnt_next        = bit_cnt_reg;
    shadow_next         = shadow_reg;
    instr_next          = instr_reg;
    cycle_next          = cycle_reg;
    counter_next        = counter_reg;
    pc_next             = pc_reg;
    branch_pending_next = branch_pending_reg;
    take_branch         = 1'b0;
    spi_select          = 1'b1;
    spi_clk_en          = 1'b0;
    spi_mosi            = 1'b0;

    case (state_reg)
      ST_START: begin
        bit_cnt_next = 5'd0;
        state_next   = ST_CMD;
      end

      ST_CMD: begin
        spi_select   = 1'b0;
        spi_clk_en   = 1'b1;
        spi_mosi     = CMD_READ[~bit_cnt_reg[2:0]];
        bit_cnt_next = bit_cnt_reg + 5'd1;
        if (bit_cnt_reg == 5'd7) begin
          bit_cnt_next = 5'd0;
          state_next   = ST_ADDR;
        end
      end

      ST_ADDR: begin
        spi_select   = 1'b0;
        spi_clk_en   = 1'b1;
        spi_mosi     = pc_reg[5'd23 - bit_cnt_reg];
        bit_cnt_next = bit_cnt_reg + 5'd1;
        if (bit_cnt_reg == 5'd23) begin
          bit_cnt_next = 5'd0;
          state_next   = ST_FILL;
        end
      end

      ST_FILL: begin
        spi_select   = 1'b0;
        spi_clk_en   = 1'b1;
        shadow_next  = shadow_fill;
        bit_cnt_next = bit_cnt_reg + 5'd1;
        if (bit_cnt_reg == 5'd31) begin
          instr_next   = shadow_fill;
          cycle_next   = 3'd0;
          counter_next = 5'd0;
          state_next   = ST_EXEC;
        end
      end

      ST_EXEC: begin
        // Later cycles gate SCLK but keep select low so the flash stream just pauses.
        spi_select   = 1'b0;
        counter_next = counter_reg + 5'd1;
        if (cycle_reg == 3'd0) begin
          spi_clk_en  = 1'b1;
          shadow_next = shadow_fill;
        end
        if (counter_reg == 5'd31) begin
          if ((cycle_reg == 3'd0) && branch) begin
            branch_pending_next = 1'b1;
          end
          take_branch = branch_pending_reg || ((cycle_reg == 3'd0) && branch);
          if (cycle_reg == last_cycle) begin
            cycle_next = 3'd0;
            if (take_branch) begin
              pc_next             = data_out & ~32'h1;
              branch_pending_next = 1'b0;
              instr_next          = INSTR_NOP;
              state_next          = ST_START;
            end else begin
              pc_next    = pc_reg + 32'd4;
              instr_next = shadow_next;
            end
          end else begin
            cycle_next = cycle_reg + 3'd1;
          end
        end
      end

      default: begin
        state_next = ST_START;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg          <= ST_START;
      bit_cnt_reg        <= 5'd0;
      shadow_reg         <= 32'd0;
      instr_reg          <= INSTR_NOP;
      cycle_reg          <= 3'd0;
      counter_reg        <= 5'd0;
      pc_reg             <= {8'h00, RESET_ADDR};
      branch_pending_reg <= 1'b0;
    end else begin
      state_reg          <= state_next;
      bit_cnt_reg        <= bit_cnt_next;
      shadow_reg         <= shadow_next;
      instr_reg          <= instr_next;
      cycle_reg          <= cycle_next;
      counter_reg        <= counter_next;
      pc_reg             <= pc_next;
      branch_pending_reg <= branch_pending_next;
    end
  end

  assign instr   = instr_reg;
  assign cycle   = cycle_reg;
  assign counter = counter_reg;
  assign pc      = pc_reg[counter_reg];

endmodule

// File: tb/tb_nanov_fetch.sv
// Bench for nanov_fetch: SPI flash model plus a scoreboard of retired instructions
// (instr, serial pc word, cycle count) and of flash read commands.
module tb_nanov_fetch;

  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] I_JAL = 32'h030000EF;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        spi_miso = 1'b0;
  logic        spi_select;
  logic        spi_clk_en;
  logic        spi_mosi;
  logic [31:0] instr;
  logic [2:0]  cycle;
  logic [4:0]  counter;
  logic        pc;
  logic        branch = 1'b0;
  logic [31:0] data_out = 32'd0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    int          ncyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] addr_q[$];
  logic [7:0]  mem [0:255];

  always #5 clk = ~clk;

  nanov_fetch #(.RESET_ADDR(24'h000000)) dut (
    .clk(clk),
    .rstn(rstn),
    .spi_miso(spi_miso),
    .spi_select(spi_select),
    .spi_clk_en(spi_clk_en),
    .spi_mosi(spi_mosi),
    .instr(instr),
    .cycle(cycle),
    .counter(counter),
    .pc(pc),
    .branch(branch),
    .data_out(data_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put_word(input int a, input logic [31:0] w);
    mem[a]     = w[7:0];
    mem[a + 1] = w[15:8];
    mem[a + 2] = w[23:16];
    mem[a + 3] = w[31:24];
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_select"}, 32'(spi_select), 32'd1);
    check({tag, "_clk_en"}, 32'(spi_clk_en), 32'd0);
    check({tag, "_mosi"}, 32'(spi_mosi), 32'd0);
    check({tag, "_instr"}, instr, NOP);
    check({tag, "_cycle_counter"}, 32'({cycle, counter}), 32'd0);
    check({tag, "_pc"}, 32'(pc), 32'd0);
  endtask

  // Flash model: SCLK rises on falling clk while enabled; 32 command bits, then data.
  int          nrise = 0;
  logic [31:0] cmd_word = 32'd0;
  logic [23:0] faddr = 24'd0;
  always @(negedge clk) begin
    int m;
    int idx;
    logic [7:0]  b;
    logic [23:0] ea;
    if (spi_select || !rstn) begin
      nrise = 0;
    end else if (spi_clk_en) begin
      if (nrise < 32) begin
        cmd_word = {cmd_word[30:0], spi_mosi};
        if (nrise == 31) begin
          faddr = cmd_word[23:0];
          if (addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL flash_cmd: got %h expected no read", cmd_word);
          end else begin
            ea = addr_q.pop_front();
            check("flash_cmd", cmd_word, {8'h03, ea});
          end
          $display("flash read cmd=%h", cmd_word);
        end
      end else begin
        m   = nrise - 32;
        idx = (int'(faddr) + m / 8) % 256;
        b   = mem[idx];
        spi_miso = b[7 - (m % 8)];
      end
      nrise++;
    end
  end

  // Monitor: rebuild the serial pc word per cycle and retire instructions at counter 31.
  logic [31:0] pcw0, pcw1;
  int          en0 = 0;
  int          lo1 = 0;
  bit          expect_c1 = 0;
  bit          expect_c0 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      expect_c1 = 0;
      expect_c0 = 0;
    end else begin
      if (expect_c1) begin
        check("cycle_to_1", 32'({cycle, counter}), 32'({3'd1, 5'd0}));
        expect_c1 = 0;
      end
      if (expect_c0) begin
        check("cycle_to_0", 32'({cycle, counter}), 32'd0);
        expect_c0 = 0;
      end
      if (cycle == 3'd0) begin
        pcw0[counter] = pc;
        if (counter == 5'd0) en0 = 0;
        if (spi_clk_en) en0++;
        if (counter == 5'd31) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_instr: got %h expected none", instr);
          end else begin
            e = exp_q[0];
            check("instr", instr, e.instr);
            check("pc_cycle0", pcw0, e.pc);
            check("clk_en_cycle0", 32'(en0), 32'd32);
            $display("retire pc=%h instr=%h cycles=%0d", pcw0, instr, e.ncyc);
            if (e.ncyc == 2) begin
              expect_c1 = 1;
            end else begin
              void'(exp_q.pop_front());
              expect_c0 = 1;
            end
          end
        end
      end else if (cycle == 3'd1) begin
        pcw1[counter] = pc;
        if (counter == 5'd0) lo1 = 0;
        if (!spi_clk_en) lo1++;
        if (counter == 5'd31) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_cycle1: got %h expected none", instr);
          end else begin
            e = exp_q.pop_front();
            check("pc_cycle1", pcw1, e.pc);
            check("clk_en_low_cycle1", 32'(lo1), 32'd32);
            expect_c0 = 1;
          end
        end
      end else begin
        check("cycle_range", 32'(cycle), 32'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    put_word(8'h00, 32'h00100513);
    put_word(8'h04, 32'h00200593);
    put_word(8'h08, 32'h00151513);
    put_word(8'h0C, NOP);
    put_word(8'h10, I_JAL);
    put_word(8'h14, NOP);
    put_word(8'h40, 32'h00300613);
    put_word(8'h44, 32'h00400693);
    put_word(8'h48, 32'h00500713);

    exp_q.push_back('{32'h00100513, 32'h00, 1});
    exp_q.push_back('{32'h00200593, 32'h04, 1});
    exp_q.push_back('{32'h00151513, 32'h08, 2});
    exp_q.push_back('{NOP,          32'h0C, 1});
    exp_q.push_back('{I_JAL,        32'h10, 2});
    exp_q.push_back('{32'h00300613, 32'h40, 1});
    exp_q.push_back('{32'h00400693, 32'h44, 1});
    exp_q.push_back('{32'h00500713, 32'h48, 1});
    addr_q.push_back(24'h000000);
    addr_q.push_back(24'h000040);
    addr_q.push_back(24'h000000);

    repeat (3) @(posedge clk);
    #1;
    check_reset("por");

    @(posedge clk);
    #3;
    rstn = 1'b1;
    #1;
    check("select_before_edge1", 32'(spi_select), 32'd1);
    tick();
    check("select_fall", 32'(spi_select), 32'd0);
    check("cmd_first_mosi", 32'(spi_mosi), 32'd0);
    repeat (63) tick();
    check("instr_nop_edge64", instr, NOP);
    tick();
    check("instr_edge65", instr, 32'h00100513);
    check("exec_start", 32'({cycle, counter}), 32'd0);

    n = 0;
    while (instr != I_JAL && n < 400) begin tick(); n++; end
    check("reach_jal", instr, I_JAL);
    branch   = 1'b1;
    data_out = 32'h00000040;
    n = 0;
    while (cycle != 3'd1 && n < 40) begin tick(); n++; end
    branch = 1'b0;
    check("jal_cycle1", 32'(cycle), 32'd1);
    n = 0;
    while (instr == I_JAL && n < 40) begin tick(); n++; end
    check("select_pulse", 32'(spi_select), 32'd1);
    check("nop_after_branch", instr, NOP);
    tick();
    check("select_pulse_end", 32'(spi_select), 32'd0);
    repeat (63) tick();
    check("nop_during_refetch", instr, NOP);
    tick();
    check("instr_branch_target", instr, 32'h00300613);
    data_out = 32'd0;

    n = 0;
    while (counter != 5'd5 && n < 10) begin tick(); n++; end
    branch   = 1'b1;
    data_out = 32'h00000080;
    tick();
    branch   = 1'b0;
    data_out = 32'd0;

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin tick(); n++; end
    check("queue_drain", 32'(exp_q.size()), 32'd0);

    #2;
    rstn = 1'b0;
    #1;
    check_reset("rst_exec");
    repeat (2) tick();

    @(posedge clk);
    #3;
    rstn = 1'b1;
    repeat (15) tick();
    check("in_addr_select", 32'(spi_select), 32'd0);
    #2;
    rstn = 1'b0;
    #1;
    check_reset("rst_addr");
    repeat (2) tick();

    exp_q.push_back('{32'h00100513, 32'h00, 1});
    @(posedge clk);
    #3;
    rstn = 1'b1;
    repeat (64) tick();
    check("restart_nop_edge64", instr, NOP);
    tick();
    check("restart_instr_edge65", instr, 32'h00100513);
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin tick(); n++; end
    check("restart_drain", 32'(exp_q.size()), 32'd0);
    check("flash_reads_done", 32'(addr_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
